// File: rtl/vco_edge_quantizer.sv
// VCO-ADC back end: synchronizes vco_p, counts rising edges per wl-cycle window and queues the counts.
// Sample ready in FIFO 1 cycle after window end; consumer stall fills FIFO, then new samples drop and set overflow.
module vco_edge_quantizer #(
    parameter int CNT_W      = 12,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             vco_p,
    output logic             vco_enb,
    output logic [CNT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overflow,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic              vco_enb_q, vco_enb_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic [WIN_W-1:0]  wcnt_q, wcnt_d;
    logic [WIN_W-1:0]  wl_q, wl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;

    logic              edge_det;
    logic              terminal;
    logic [CNT_W-1:0]  sample_val;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              ovf_clr;

    always_comb begin
        edge_det   = s2_q & ~s3_q;
        terminal   = (wcnt_q == wl_q - WIN_W'(1));
        sample_val = (edge_det && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = sample_valid & sample_ready;

        state_d   = state_q;
        vco_enb_d = vco_enb_q;
        scnt_d    = scnt_q;
        wcnt_d    = wcnt_q;
        wl_d      = wl_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        ovf_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                vco_enb_d = 1'b1;
                scnt_d    = '0;
                wcnt_d    = '0;
                cnt_d     = '0;
                if (en) begin
                    // Windows shorter than 2 cycles cannot resolve an edge; clamp.
                    wl_d      = (win_len < WIN_W'(2)) ? WIN_W'(2) : win_len;
                    state_d   = SETTLE;
                    vco_enb_d = 1'b0;
                    ovf_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_d   = IDLE;
                    vco_enb_d = 1'b1;
                end else if (scnt_q == SW'(SETTLE_CYC - 1)) begin
                    state_d = COUNT;
                    wcnt_d  = '0;
                    cnt_d   = '0;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d   = IDLE;
                    vco_enb_d = 1'b1;
                end else if (terminal) begin
                    // Back-to-back windows: the next one starts on the following cycle.
                    push   = 1'b1;
                    wcnt_d = '0;
                    cnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WIN_W'(1);
                    cnt_d  = sample_val;
                end
            end
            default: begin
                state_d   = IDLE;
                vco_enb_d = 1'b1;
            end
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok  = push & (~full | pop);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = sample_val;
        end
        wr_ptr_d   = wr_ptr_q + (push_ok ? PW'(1) : PW'(0));
        rd_ptr_d   = rd_ptr_q + (pop ? PW'(1) : PW'(0));
        overflow_d = ovf_clr ? 1'b0 : (overflow_q | (push & ~push_ok));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            vco_enb_q  <= 1'b1;
            scnt_q     <= '0;
            wcnt_q     <= '0;
            wl_q       <= WIN_W'(2);
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            s1_q       <= vco_p;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            vco_enb_q  <= vco_enb_d;
            scnt_q     <= scnt_d;
            wcnt_q     <= wcnt_d;
            wl_q       <= wl_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign vco_enb      = vco_enb_q;
    assign sample_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign sample_valid = (wr_ptr_q != rd_ptr_q);
    assign overflow     = overflow_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: doc/vco_edge_quantizer.md
Name: vco_edge_quantizer

Overview:
- Digital back end of the VCO-ADC; sits directly downstream of the vco block.
- Gates the VCO through its active-low enb input.
- Synchronizes the 1-bit VCO phase output p, counts its rising edges over a programmable window and emits one count per window as an ADC sample.
- Samples are buffered in a small FIFO with a valid/ready interface toward the decimation filter.

Parameters:
- CNT_W, 12: width of the edge counter and of each output sample.
- WIN_W, 16: width of the window-length input.
- SETTLE_CYC, 4: cycles discarded after the VCO is enabled, before the first window opens.
- FIFO_DEPTH, 4: number of sample entries in the output FIFO (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  conversion enable, level sensitive.
- win_len  in  WIN_W  window length in clk cycles; latched when leaving IDLE.
- vco_p  in  1  asynchronous VCO phase output p.
- vco_enb  out  1  drives the vco enb input; 0 = VCO running.
- sample_data  out  CNT_W  FIFO head: edge count of one window.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accepts the head entry when valid & ready.
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: vco_enb=1, sample_valid=0, sample_data=0, overflow=0, busy=0. The FIFO is emptied and the state is IDLE.
- Synchronizer: two flops s1, s2 plus a history flop s3. edge = s2 & ~s3. Pipeline latency from a vco_p rise to edge is 2 to 3 cycles. The maximum resolvable rate is one edge per 2 clk cycles.
- The synchronizer and history flops reset to 0 and keep running in every state.
- IDLE:
  - vco_enb=1, counters cleared.
  - When en=1: latch wl = max(win_len, 2), then go to SETTLE. vco_enb=0 starting the next cycle.
- SETTLE:
  - Hold for SETTLE_CYC cycles; edges are ignored.
  - Then go to COUNT with cnt=0 and wcnt=0.
- COUNT:
  - Each cycle: wcnt increments; cnt increments on edge, saturating at 2^CNT_W-1.
  - Terminal cycle is wcnt == wl-1. The sample value is cnt plus that cycle's edge, saturated.
  - Also on the terminal cycle: push the sample into the FIFO, set wcnt=0 and cnt=0, and start the next window immediately. No cycles are lost between windows.
  - Each window is exactly wl cycles. The first sample is pushed SETTLE_CYC+wl cycles after leaving IDLE.
- en=0 in SETTLE or COUNT:
  - Return to IDLE on the next cycle and discard the partial window; nothing is pushed.
  - vco_enb=1 on the next cycle.
  - Already buffered FIFO entries remain readable.
- FIFO:
  - Show-ahead: sample_data is the head entry whenever sample_valid=1. sample_data holds its value until popped.
  - Pop occurs on sample_valid & sample_ready.
  - Push when full: the new sample is dropped and overflow sets.
  - Simultaneous push and pop when full: the pop frees the slot and the push is accepted; no overflow.
  - Simultaneous push and pop when empty: the push is written and sample_valid=1 the next cycle.
  - Occupancy is tracked with pointers of width log2(FIFO_DEPTH)+1.
- overflow: sticky. Cleared only by rst or by the IDLE->SETTLE transition.
- win_len changes while busy have no effect until the next IDLE exit.
- rst mid-operation: everything returns to its reset value in the same clock edge, including the FIFO contents.

Test Plan:
- Square wave: vco_p period 8 clk, win_len=32, en=1, sample_ready=1 → every sample after the first = 4. First push occurs 36 cycles after en is sampled; vco_enb falls 1 cycle after en.
- Saturation: CNT_W=4, vco_p period 2 clk, win_len=64 → samples = 15 (saturated, not 0 or wrapped).
- Backpressure: sample_ready=0, vco_p period 4 clk, win_len=16 → 4 entries of value 4 stored. The 5th push is dropped and overflow=1. Then set ready=1 → exactly 4 pops, sample_valid=0, overflow stays 1.
- Full-with-pop: FIFO full and the pop lands in the same cycle as a push → occupancy stays 4, overflow stays 0.
- Abort: drop en at wcnt=10 of the 3rd window → no 3rd sample pushed; vco_enb=1 next cycle; the 2 stored samples remain readable. Re-assert en → overflow clears and SETTLE restarts.
- Reset mid-COUNT with 2 entries buffered → the next cycle shows sample_valid=0, vco_enb=1, busy=0, overflow=0. win_len=0 or 1 afterwards → windows of 2 cycles.
